// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline issue controller: instruction field positions,
// the buffered command payload, and the issue FSM states.
package pipe_ctrl_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned WDATA_W = 16;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned ALU_W   = 4;
   localparam int unsigned MADDR_W = 8;
   localparam int unsigned PERF_W  = 16;

   localparam int unsigned ALU_SEL_LSB  = 28;
   localparam int unsigned RD_LSB       = 23;
   localparam int unsigned RS1_LSB      = 18;
   localparam int unsigned RS2_LSB      = 13;
   localparam int unsigned REG_WE_BIT   = 12;
   localparam int unsigned MEM_WE_BIT   = 11;
   localparam int unsigned MEM_RE_BIT   = 10;
   localparam int unsigned WB_SEL_BIT   = 9;
   localparam int unsigned MEM_ADDR_LSB = 1;
   localparam int unsigned RSVD_BIT     = 0;

   typedef struct packed {
      logic [ALU_W-1:0]   alu_sel;
      logic [REG_AW-1:0]  rd;
      logic [REG_AW-1:0]  rs1;
      logic [REG_AW-1:0]  rs2;
      logic               reg_we;
      logic               mem_we;
      logic               mem_re;
      logic               wb_sel;
      logic [MADDR_W-1:0] mem_addr;
      logic [WDATA_W-1:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;

   // Reserved bit 0 is not part of the command, so it is not passed in.
   function automatic cmd_t decode_cmd(input logic [INSTR_W-1:1] instr,
                                       input logic [WDATA_W-1:0] wdata);
      cmd_t c;
      c.alu_sel  = instr[ALU_SEL_LSB +: ALU_W];
      c.rd       = instr[RD_LSB +: REG_AW];
      c.rs1      = instr[RS1_LSB +: REG_AW];
      c.rs2      = instr[RS2_LSB +: REG_AW];
      c.reg_we   = instr[REG_WE_BIT];
      c.mem_we   = instr[MEM_WE_BIT];
      c.mem_re   = instr[MEM_RE_BIT];
      c.wb_sel   = instr[WB_SEL_BIT];
      c.mem_addr = instr[MEM_ADDR_LSB +: MADDR_W];
      c.wdata    = wdata;
      return c;
   endfunction

endpackage

// File: rtl/issue_fifo.sv
// Command FIFO for the issue controller; clear empties it in one edge and
// takes priority over push/pop.
module issue_fifo import pipe_ctrl_pkg::*; #(
   parameter int unsigned DEPTH = 4
) (
   input  logic phi1_clk,
   input  logic main_rst,
   input  logic clear,
   input  logic push,
   input  logic pop,
   input  cmd_t wr_data,
   output cmd_t rd_data,
   output logic full,
   output logic empty,
   output logic last
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   cmd_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign last    = (count == (AW+1)'(1));
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge phi1_clk or posedge main_rst) begin
      if (main_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge phi1_clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller for the RF/EX/MEM/WB datapath: FIFO-buffered commands,
// RAW scoreboard with bubbles, flush/drain. PIPE_ISSUE_PERF_EN adds counters.
module pipe_issue_ctrl import pipe_ctrl_pkg::*; #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WB_LAT     = 3
) (
   input  logic               phi1_clk,
   input  logic               main_rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [WDATA_W-1:0] in_wdata,
   input  logic               flush,
   output logic [REG_AW-1:0]  dp_rs1_addr,
   output logic [REG_AW-1:0]  dp_rs2_addr,
   output logic [REG_AW-1:0]  dp_rd_addr,
   output logic               dp_reg_we,
   output logic [ALU_W-1:0]   dp_alu_sel,
   output logic [MADDR_W-1:0] dp_mem_addr,
   output logic               dp_mem_we,
   output logic               dp_mem_re,
   output logic [WDATA_W-1:0] dp_mem_wdata,
   output logic               dp_wb_sel,
   output logic               busy,
`ifdef PIPE_ISSUE_PERF_EN
   output logic [PERF_W-1:0]  perf_issue_cnt,
   output logic [PERF_W-1:0]  perf_stall_cnt,
`endif
   output logic               stall
);

   cmd_t              in_cmd;
   cmd_t              head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_last;
   logic              push;
   logic              issue;
   logic              hazard;
   logic              sb_drain_busy;
   logic              rsvd_unused;
   state_t            state;
   logic [WB_LAT-1:0] sb_v;
   logic [REG_AW-1:0] sb_rd [WB_LAT];

   assign rsvd_unused = in_instr[RSVD_BIT];
   assign in_cmd      = decode_cmd(in_instr[INSTR_W-1:1], in_wdata);
   assign in_ready    = !fifo_full && !flush && (state != DRAIN);
   assign push        = in_valid && in_ready;
   assign issue       = !fifo_empty && !hazard && !flush && (state != DRAIN);
   assign busy        = !fifo_empty || (|sb_v) || (state != IDLE);
   // Scoreboard occupancy after this edge's shift, given a bubble enters.
   assign sb_drain_busy = |(sb_v << 1);

   issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .phi1_clk (phi1_clk),
      .main_rst (main_rst),
      .clear    (flush),
      .push     (push),
      .pop      (issue),
      .wr_data  (in_cmd),
      .rd_data  (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .last     (fifo_last)
   );

   // Both sources are always compared, whether or not the op reads them.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < int'(WB_LAT); i++) begin
         if (sb_v[i] && ((sb_rd[i] == head.rs1) || (sb_rd[i] == head.rs2))) hazard = 1'b1;
      end
   end

   always_ff @(posedge phi1_clk or posedge main_rst) begin
      if (main_rst) begin
         sb_v <= '0;
         for (int i = 0; i < int'(WB_LAT); i++) sb_rd[i] <= '0;
      end else begin
         sb_v[0]  <= issue && head.reg_we;
         sb_rd[0] <= head.rd;
         for (int i = 1; i < int'(WB_LAT); i++) begin
            sb_v[i]  <= sb_v[i-1];
            sb_rd[i] <= sb_rd[i-1];
         end
      end
   end

   always_ff @(posedge phi1_clk or posedge main_rst) begin
      if (main_rst) begin
         state <= IDLE;
         stall <= 1'b0;
      end else begin
         stall <= 1'b0;
         if (flush) begin
            state <= DRAIN;
         end else begin
            case (state)
               DRAIN: begin
                  if (!sb_drain_busy) state <= IDLE;
               end
               default: begin
                  if (fifo_empty) begin
                     state <= push ? RUN : IDLE;
                  end else if (hazard) begin
                     state <= STALL;
                     stall <= 1'b1;
                  end else if (fifo_last && !push) begin
                     state <= IDLE;
                  end else begin
                     state <= RUN;
                  end
               end
            endcase
         end
      end
   end

   // Bubbles clear only the enables; addresses and data hold.
   always_ff @(posedge phi1_clk or posedge main_rst) begin
      if (main_rst) begin
         dp_rs1_addr  <= '0;
         dp_rs2_addr  <= '0;
         dp_rd_addr   <= '0;
         dp_reg_we    <= 1'b0;
         dp_alu_sel   <= '0;
         dp_mem_addr  <= '0;
         dp_mem_we    <= 1'b0;
         dp_mem_re    <= 1'b0;
         dp_mem_wdata <= '0;
         dp_wb_sel    <= 1'b0;
      end else begin
         dp_reg_we <= 1'b0;
         dp_mem_we <= 1'b0;
         dp_mem_re <= 1'b0;
         if (issue) begin
            dp_rs1_addr  <= head.rs1;
            dp_rs2_addr  <= head.rs2;
            dp_rd_addr   <= head.rd;
            dp_reg_we    <= head.reg_we;
            dp_alu_sel   <= head.alu_sel;
            dp_mem_addr  <= head.mem_addr;
            dp_mem_we    <= head.mem_we;
            dp_mem_re    <= head.mem_re;
            dp_mem_wdata <= head.wdata;
            dp_wb_sel    <= head.wb_sel;
         end
      end
   end

`ifdef PIPE_ISSUE_PERF_EN
   always_ff @(posedge phi1_clk or posedge main_rst) begin
      if (main_rst) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (issue && (perf_issue_cnt != '1)) perf_issue_cnt <= perf_issue_cnt + PERF_W'(1);
         if ((state == STALL) && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: independent issue, RAW and load-use
// spacing, full FIFO back-pressure, flush/drain and mid-stream reset.
module tb_pipe_issue_ctrl;

   logic        phi1_clk;
   logic        main_rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [15:0] in_wdata;
   logic        flush;
   logic [4:0]  dp_rs1_addr;
   logic [4:0]  dp_rs2_addr;
   logic [4:0]  dp_rd_addr;
   logic        dp_reg_we;
   logic [3:0]  dp_alu_sel;
   logic [7:0]  dp_mem_addr;
   logic        dp_mem_we;
   logic        dp_mem_re;
   logic [15:0] dp_mem_wdata;
   logic        dp_wb_sel;
   logic        busy;
   logic        stall;
`ifdef PIPE_ISSUE_PERF_EN
   logic [15:0] perf_issue_cnt;
   logic [15:0] perf_stall_cnt;
`endif

   int checks;
   int errors;

   pipe_issue_ctrl dut (
      .phi1_clk     (phi1_clk),
      .main_rst     (main_rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_wdata     (in_wdata),
      .flush        (flush),
      .dp_rs1_addr  (dp_rs1_addr),
      .dp_rs2_addr  (dp_rs2_addr),
      .dp_rd_addr   (dp_rd_addr),
      .dp_reg_we    (dp_reg_we),
      .dp_alu_sel   (dp_alu_sel),
      .dp_mem_addr  (dp_mem_addr),
      .dp_mem_we    (dp_mem_we),
      .dp_mem_re    (dp_mem_re),
      .dp_mem_wdata (dp_mem_wdata),
      .dp_wb_sel    (dp_wb_sel),
      .busy         (busy),
`ifdef PIPE_ISSUE_PERF_EN
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .stall        (stall)
   );

   initial phi1_clk = 1'b0;
   always #5 phi1_clk = ~phi1_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge phi1_clk);
      #1;
   endtask

   // Hand-packed instruction word: alu, rd, rs1, rs2, reg_we, mem_we, mem_re, wb_sel, addr, rsvd.
   function automatic logic [31:0] mk(input logic [3:0] alu, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic we, input logic mwe, input logic mre,
                                      input logic wbs, input logic [7:0] addr);
      return {alu, rd, rs1, rs2, we, mwe, mre, wbs, addr, 1'b0};
   endfunction

   task automatic send(input logic [31:0] instr, input logic [15:0] wdata);
      in_valid = 1'b1;
      in_instr = instr;
      in_wdata = wdata;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 30) begin
         tick();
         n++;
      end
      check(tag, 32'(busy), 0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      main_rst = 1'b1;
      in_valid = 1'b0;
      in_instr = '0;
      in_wdata = '0;
      flush    = 1'b0;
      #2;
      check("rst_we",    32'(dp_reg_we), 0);
      check("rst_rd",    32'(dp_rd_addr), 0);
      check("rst_stall", 32'(stall), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_ready", 32'(in_ready), 1);
      tick();
      main_rst = 1'b0;
      tick();

      // Independent ADD then SUB/store on consecutive edges
      send(mk(4'd1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0000);
      tick();
      send(mk(4'd2, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44), 16'hBEEF);
      tick();
      check("ind_rd0",  32'(dp_rd_addr), 3);
      check("ind_we0",  32'(dp_reg_we), 1);
      check("ind_alu0", 32'(dp_alu_sel), 1);
      check("ind_rs10", 32'(dp_rs1_addr), 1);
      check("ind_rs20", 32'(dp_rs2_addr), 2);
      check("ind_st0",  32'(stall), 0);
      in_valid = 1'b0;
      tick();
      check("ind_rd1",  32'(dp_rd_addr), 4);
      check("ind_alu1", 32'(dp_alu_sel), 2);
      check("ind_rs11", 32'(dp_rs1_addr), 5);
      check("ind_mwe1", 32'(dp_mem_we), 1);
      check("ind_wd1",  32'(dp_mem_wdata), 32'hBEEF);
      check("ind_ma1",  32'(dp_mem_addr), 32'h44);
      check("ind_st1",  32'(stall), 0);
      tick();
      check("ind_bub_we",  32'(dp_reg_we), 0);
      check("ind_bub_mwe", 32'(dp_mem_we), 0);
      check("ind_bub_rd",  32'(dp_rd_addr), 4);
      check("ind_bub_wd",  32'(dp_mem_wdata), 32'hBEEF);
      check("ind_busy",    32'(busy), 1);
      wait_idle("ind_idle");

      // RAW: r7 <- r3,r0 waits three bubbles behind r3 <- r1,r2
      send(mk(4'd1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      send(mk(4'd3, 5'd7, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      check("raw_prod_rd", 32'(dp_rd_addr), 3);
      check("raw_prod_we", 32'(dp_reg_we), 1);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("raw_bub_we", 32'(dp_reg_we), 0);
         check("raw_bub_st", 32'(stall), 1);
      end
      tick();
      check("raw_cons_rd",  32'(dp_rd_addr), 7);
      check("raw_cons_we",  32'(dp_reg_we), 1);
      check("raw_cons_rs1", 32'(dp_rs1_addr), 3);
      check("raw_cons_rs2", 32'(dp_rs2_addr), 0);
      check("raw_cons_st",  32'(stall), 0);
      wait_idle("raw_idle");

      // Load-use: r9 <- mem[0x20], then r10 <- r9,r1
      send(mk(4'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h20), 16'h0);
      tick();
      send(mk(4'd1, 5'd10, 5'd9, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      check("lu_mre", 32'(dp_mem_re), 1);
      check("lu_ma",  32'(dp_mem_addr), 32'h20);
      check("lu_wbs", 32'(dp_wb_sel), 1);
      check("lu_rd",  32'(dp_rd_addr), 9);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("lu_bub_mre", 32'(dp_mem_re), 0);
         check("lu_bub_we",  32'(dp_reg_we), 0);
         check("lu_bub_ma",  32'(dp_mem_addr), 32'h20);
      end
      tick();
      check("lu_use_rd",  32'(dp_rd_addr), 10);
      check("lu_use_we",  32'(dp_reg_we), 1);
      check("lu_use_wbs", 32'(dp_wb_sel), 0);
      check("lu_use_mre", 32'(dp_mem_re), 0);
      wait_idle("lu_idle");

      // Full FIFO behind a stalled head
      send(mk(4'd1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      send(mk(4'd1, 5'd8, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      check("full_p_rd", 32'(dp_rd_addr), 3);
      send(mk(4'd1, 5'd11, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      check("full_rdy2", 32'(in_ready), 1);
      send(mk(4'd1, 5'd12, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      check("full_rdy3", 32'(in_ready), 1);
      send(mk(4'd1, 5'd13, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      check("full_rdy4", 32'(in_ready), 0);
      send(mk(4'd1, 5'd14, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      check("full_c1_rd",  32'(dp_rd_addr), 8);
      check("full_rdy_pop", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check("full_c2_rd", 32'(dp_rd_addr), 11);
      tick();
      check("full_c3_rd", 32'(dp_rd_addr), 12);
      tick();
      check("full_c4_rd", 32'(dp_rd_addr), 13);
      tick();
      check("full_c5_rd", 32'(dp_rd_addr), 14);
      check("full_c5_we", 32'(dp_reg_we), 1);
      wait_idle("full_idle");

      // Flush with two queued and one in flight
      send(mk(4'd1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      send(mk(4'd1, 5'd8, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      send(mk(4'd1, 5'd11, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      send(mk(4'd1, 5'd12, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("fl_inflight_rd", 32'(dp_rd_addr), 8);
      flush = 1'b1;
      send(mk(4'd1, 5'd20, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      #1;
      check("fl_ready_flush", 32'(in_ready), 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("fl_e1_we",    32'(dp_reg_we), 0);
      check("fl_e1_busy",  32'(busy), 1);
      check("fl_e1_ready", 32'(in_ready), 0);
      tick();
      check("fl_e2_busy", 32'(busy), 1);
      check("fl_e2_we",   32'(dp_reg_we), 0);
      tick();
      check("fl_e3_busy",  32'(busy), 0);
      check("fl_e3_ready", 32'(in_ready), 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("fl_post_we", 32'(dp_reg_we), 0);
         check("fl_post_rd", 32'(dp_rd_addr), 8);
      end

      // Reset with three commands queued
      send(mk(4'd1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      send(mk(4'd1, 5'd8, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      send(mk(4'd1, 5'd11, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      send(mk(4'd1, 5'd12, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), 16'h0);
      tick();
      in_valid = 1'b0;
      check("mr_pre_rd", 32'(dp_rd_addr), 3);
      main_rst = 1'b1;
      #1;
      check("mr_rd",    32'(dp_rd_addr), 0);
      check("mr_alu",   32'(dp_alu_sel), 0);
      check("mr_busy",  32'(busy), 0);
      check("mr_ready", 32'(in_ready), 1);
      check("mr_stall", 32'(stall), 0);
      tick();
      check("mr_edge_busy", 32'(busy), 0);
      check("mr_edge_we",   32'(dp_reg_we), 0);
      main_rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("mr_post_we", 32'(dp_reg_we), 0);
      end
      check("mr_post_busy", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
